ibex_rvfi_trace_buffer: RTL and testbench
=========================================

# ibex_rvfi_trace_buffer

Synthesizable, parametrised successor to the simulation-only RVFI tracer. It sits beside `ibex_top` on the RVFI retirement bus. It filters retired instructions, optionally waits for a PC trigger, and time-stamps each record. Records are buffered in a configurable-depth FIFO with stream, stop-on-full or circular-overwrite policy, and drained through a valid/ready port for on-chip debug or DMA.

## Interface
Parameters:
- `Depth`, 16: FIFO entries; power of two, ≥2.
- `TsWidth`, 16: timestamp counter width.
- `DropCntWidth`, 16: saturating drop counter width.

Ports:
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `cfg_en_i`  in  1  capture enable (level).
- `cfg_mode_i`  in  2  0 STREAM, 1 STOP, 2 CIRCULAR; 3 is reserved and behaves as STREAM.
- `cfg_filter_i`  in  3  bit0 all retirements, bit1 traps, bit2 memory ops (OR of selected bits).
- `cfg_trig_en_i`  in  1  wait for PC trigger before capturing.
- `cfg_trig_pc_i`  in  32  trigger PC.
- `clear_i`  in  1  synchronous flush and counter clear.
- `rvfi_valid`, `rvfi_trap`  in  1  retirement strobe and trap flag.
- `rvfi_insn`, `rvfi_pc_rdata`, `rvfi_rd_wdata`  in  32 each.
- `rvfi_rd_addr`  in  5.
- `rvfi_mem_rmask`, `rvfi_mem_wmask`  in  4 each.
- `trace_valid_o`  out  1  head record valid.
- `trace_ready_i`  in  1  consumer accepts head.
- `trace_rec_o`  out  104+TsWidth  {ts, trap, mem_w, mem_r, rd_addr, rd_wdata, insn, pc}, where mem_r = |rmask and mem_w = |wmask.
- `level_o`  out  $clog2(Depth)+1  occupancy.
- `full_o`  out  1  level == Depth.
- `drop_cnt_o`  out  DropCntWidth  records lost since clear; saturates.
- `overflow_o`  out  1  sticky; set on any drop or overwrite.
- `capturing_o`  out  1  FSM in CAPTURE.

## Operation
- FSM states IDLE, ARMED, CAPTURE, FROZEN.
  - Any state: `cfg_en_i` low → IDLE. Buffered records remain drainable.
  - IDLE: `cfg_en_i` high → ARMED if `cfg_trig_en_i`, else CAPTURE.
  - ARMED: a retirement with pc == `cfg_trig_pc_i` → CAPTURE. The trigger instruction itself is a capture candidate.
  - CAPTURE, STOP mode: a push that makes level == Depth → FROZEN.
  - FROZEN: retirements are ignored and not counted. Exit only via `clear_i` or disable.
- Candidate = `rvfi_valid` & state permits & filter match.
- Push policy when full with no pop in the same cycle:
  - STREAM: record dropped, `drop_cnt_o`++ and `overflow_o` set.
  - CIRCULAR: oldest entry discarded and new entry written, `drop_cnt_o`++ and `overflow_o` set.
  - STOP: cannot occur, because the FSM is already FROZEN.
- Full with a pop in the same cycle: push accepted in all modes, level unchanged.
- `clear_i`: empties the FIFO, zeroes `drop_cnt_o` and `overflow_o`, and re-enters the IDLE→ transition for the current `cfg_en_i`. It has priority over a same-cycle push or pop.
- Timestamp: free-running TsWidth counter, reset 0, wraps modulo 2^TsWidth. The record carries the value in the retirement cycle.
- `drop_cnt_o` holds at all-ones once saturated.

## Timing
- Reset values: all outputs 0, state IDLE, timestamp 0, pointers 0.
- Capture latency: retirement at cycle N → `trace_valid_o` and record visible at N+1 (registered write, flop-array head read).
- Pop occurs when `trace_valid_o & trace_ready_i`. The next entry appears in the following cycle with no bubble.
- STREAM/STOP stability: `trace_rec_o` stays stable while valid & !ready.
- CIRCULAR: the head may advance under stall. The consumer samples only on handshake.
- `level_o`, `full_o`, `drop_cnt_o` and `overflow_o` update one cycle after the causing event.
- The trigger compare is combinational on the current RVFI inputs. ARMED→CAPTURE takes effect so that the trigger record is pushed at N+1.
- An asserted reset mid-operation discards all contents immediately.

## Structure
- Package `ibex_trace_pkg`:
  - `trace_mode_e` (STREAM, STOP, CIRCULAR)
  - `trace_state_e`
  - record struct `trace_rec_t` and its field-width constants
  - filter bit indices
- Sub-module `ibex_trace_fifo`:
  - flop-array FIFO with pointer wrap and an extra occupancy bit
  - `overwrite_i` input for circular mode
  - outputs level and full
- Top module holds the FSM, filter, trigger, timestamp counter and drop counter.

## Test plan
- Depth=4, STREAM, filter=all, ready=0, 6 retirements → level 4, `full_o`=1, `drop_cnt_o`=2, `overflow_o`=1. Draining then yields pc of retirements 1–4 in order.
- Depth=4, STOP, 5 retirements → FROZEN after the 4th, `drop_cnt_o`=0. `clear_i` → level 0 and FSM returns to CAPTURE.
- Depth=4, CIRCULAR, 6 retirements with pcs 0x100..0x114 step 4, ready=0 → drain returns 0x108, 0x10C, 0x110, 0x114, `drop_cnt_o`=2.
- Trigger 0x80 with retirements at 0x7C, 0x80, 0x84 → only 0x80 and 0x84 captured. `capturing_o` rises the cycle after 0x80 retires.
- Filter=traps|mem: a plain ALU op, a load (rmask=0xF) and an ecall (trap) → two records, with mem_r=1 on the first and trap=1 on the second.
- Full buffer with simultaneous push and pop, then reset asserted mid-drain → level stays 4 on the push/pop cycle, and all outputs are 0 during reset.

Source files
------------

// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace buffer.
// Contents:
//   - trace_mode_e : buffering policy (STREAM / STOP / CIRCULAR)
//   - trace_state_e: capture FSM states
//   - trace_rec_t  : the fixed part of a trace record. The timestamp is
//                    concatenated above it, because its width is a module
//                    parameter.
//   - field-width constants and filter bit indices
//   - decode_mode(): maps the raw 2-bit mode. The reserved code 3 is
//                    treated as STREAM.
package ibex_trace_pkg;

    localparam int unsigned PcWidth      = 32;
    localparam int unsigned InsnWidth    = 32;
    localparam int unsigned DataWidth    = 32;
    localparam int unsigned RegAddrWidth = 5;
    // trap + mem_w + mem_r + rd_addr + rd_wdata + insn + pc
    localparam int unsigned RecCoreWidth = 3 + RegAddrWidth + DataWidth + InsnWidth + PcWidth;

    // Bit positions inside cfg_filter_i
    localparam int unsigned FiltAll  = 0;
    localparam int unsigned FiltTrap = 1;
    localparam int unsigned FiltMem  = 2;

    typedef enum logic [1:0] {
        STREAM   = 2'd0,
        STOP     = 2'd1,
        CIRCULAR = 2'd2
    } trace_mode_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FROZEN  = 2'd3
    } trace_state_e;

    // The first member is the MSB, so the packed layout is
    // {trap, mem_w, mem_r, rd_addr, rd_wdata, insn, pc}.
    typedef struct packed {
        logic                    trap;
        logic                    mem_w;
        logic                    mem_r;
        logic [RegAddrWidth-1:0] rd_addr;
        logic [DataWidth-1:0]    rd_wdata;
        logic [InsnWidth-1:0]    insn;
        logic [PcWidth-1:0]      pc;
    } trace_rec_t;

    function automatic trace_mode_e decode_mode(input logic [1:0] raw);
        trace_mode_e m;
        m = (raw == 2'd3) ? STREAM : trace_mode_e'(raw);
        return m;
    endfunction

endpackage

// File: rtl/ibex_rvfi_trace_buffer_if.sv
// Bus bundle for the trace buffer.
// Groups the RVFI retirement inputs with the valid/ready drain port.
//   master: the environment. It drives RVFI and trace_ready_i, and it
//           observes the trace output.
//   slave : the trace buffer. It consumes RVFI and produces trace records.
interface ibex_rvfi_trace_buffer_if
    import ibex_trace_pkg::*;
#(
    parameter int unsigned TsWidth = 16
) ();
    logic                        rvfi_valid;
    logic                        rvfi_trap;
    logic [InsnWidth-1:0]        rvfi_insn;
    logic [PcWidth-1:0]          rvfi_pc_rdata;
    logic [DataWidth-1:0]        rvfi_rd_wdata;
    logic [RegAddrWidth-1:0]     rvfi_rd_addr;
    logic [3:0]                  rvfi_mem_rmask;
    logic [3:0]                  rvfi_mem_wmask;

    logic                        trace_valid_o;
    logic                        trace_ready_i;
    logic [RecCoreWidth+TsWidth-1:0] trace_rec_o;

    modport master (
        output rvfi_valid, rvfi_trap, rvfi_insn, rvfi_pc_rdata, rvfi_rd_wdata,
               rvfi_rd_addr, rvfi_mem_rmask, rvfi_mem_wmask, trace_ready_i,
        input  trace_valid_o, trace_rec_o
    );

    modport slave (
        input  rvfi_valid, rvfi_trap, rvfi_insn, rvfi_pc_rdata, rvfi_rd_wdata,
               rvfi_rd_addr, rvfi_mem_rmask, rvfi_mem_wmask, trace_ready_i,
        output trace_valid_o, trace_rec_o
    );
endinterface

// File: rtl/ibex_trace_fifo.sv
// Flop-array FIFO for trace records.
// The head is read combinationally from the array, so a word written at
// edge N is visible right after that edge.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous flush. It has priority over push and pop.
//   push_i/data_i : write request and data
//   overwrite_i   : when full with no pop, discard the oldest entry and
//                   accept the push. When this is low, the push is ignored.
//   pop_i         : remove the head. Ignored when the FIFO is empty.
//   data_o/valid_o: head entry and non-empty flag
//   level_o/full_o: occupancy. It carries an extra bit so that Depth itself
//                   can be represented.
module ibex_trace_fifo
    import ibex_trace_pkg::*;
#(
    parameter  int unsigned Depth = 16,
    parameter  int unsigned Width = 120,
    localparam int unsigned AddrW = $clog2(Depth),
    localparam int unsigned LvlW  = AddrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             overwrite_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             valid_o,
    output logic [LvlW-1:0]  level_o,
    output logic             full_o
);
    localparam logic [LvlW-1:0] DepthLvl = LvlW'(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]  level_q;

    logic full, empty, pop_ok, push_ok, discard, rd_adv;

    assign full    = (level_q == DepthLvl);
    assign empty   = (level_q == '0);
    assign pop_ok  = pop_i & ~empty;
    // A same-cycle pop frees a slot, so a push into a full FIFO is still
    // accepted in that case.
    assign push_ok = push_i & (~full | pop_ok | overwrite_i);
    // Circular overwrite: the read pointer steps past the oldest entry.
    assign discard = push_i & full & ~pop_ok & overwrite_i;
    assign rd_adv  = pop_ok | discard;

    // Pointers wrap naturally because Depth is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_adv)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !rd_adv)      level_q <= level_q + 1'b1;
            else if (rd_adv && !push_ok) level_q <= level_q - 1'b1;
        end
    end

    // The storage array has no reset. Stale contents are never exposed,
    // because valid_o gates every use of them.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = ~empty;
    assign level_o = level_q;
    assign full_o  = full;
endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// Synthesizable RVFI trace buffer.
// It filters retirements and can wait for a PC trigger before capturing.
// Each record is time-stamped and buffered in a FIFO, using one of three
// policies: stream, stop-on-full or circular overwrite.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   cfg_en_i           : capture enable (level)
//   cfg_mode_i         : 0 STREAM, 1 STOP, 2 CIRCULAR (3 behaves as STREAM)
//   cfg_filter_i       : bit0 all, bit1 traps, bit2 memory ops (ORed)
//   cfg_trig_en_i/_pc_i: wait for a retirement at this PC before capturing
//   clear_i            : flush the FIFO, clear drop count and overflow flag
//   bus (slave)        : RVFI inputs plus the trace valid/ready/record port
//   level_o, full_o    : FIFO occupancy
//   drop_cnt_o         : saturating count of lost records
//   overflow_o         : sticky flag, set on any drop or overwrite
//   capturing_o        : FSM is in CAPTURE
module ibex_rvfi_trace_buffer
    import ibex_trace_pkg::*;
#(
    parameter  int unsigned Depth        = 16,
    parameter  int unsigned TsWidth      = 16,
    parameter  int unsigned DropCntWidth = 16,
    localparam int unsigned LvlW         = $clog2(Depth) + 1,
    localparam int unsigned RecW         = RecCoreWidth + TsWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_en_i,
    input  logic [1:0]              cfg_mode_i,
    input  logic [2:0]              cfg_filter_i,
    input  logic                    cfg_trig_en_i,
    input  logic [PcWidth-1:0]      cfg_trig_pc_i,
    input  logic                    clear_i,
    ibex_rvfi_trace_buffer_if.slave bus,
    output logic [LvlW-1:0]         level_o,
    output logic                    full_o,
    output logic [DropCntWidth-1:0] drop_cnt_o,
    output logic                    overflow_o,
    output logic                    capturing_o
);
    localparam logic [LvlW-1:0] LastSlot = LvlW'(Depth - 1);

    trace_state_e            state_q, state_d;
    trace_mode_e             mode;
    logic [TsWidth-1:0]      ts_q;
    logic [DropCntWidth-1:0] drop_cnt_q;
    logic                    overflow_q;

    trace_rec_t              rec_core;
    logic [RecW-1:0]         rec_in, rec_head;
    logic                    fifo_valid, fifo_full;
    logic [LvlW-1:0]         fifo_level;

    logic is_mem, filter_hit, trig_hit, permit, cand, pop, drop, freeze_hit;

    assign mode   = decode_mode(cfg_mode_i);
    assign is_mem = (|bus.rvfi_mem_rmask) | (|bus.rvfi_mem_wmask);

    assign filter_hit = cfg_filter_i[FiltAll]
                      | (cfg_filter_i[FiltTrap] & bus.rvfi_trap)
                      | (cfg_filter_i[FiltMem]  & is_mem);

    // The trigger compare is combinational, so the trigger instruction can
    // itself be captured in the same cycle the FSM leaves ARMED.
    assign trig_hit = bus.rvfi_valid & (bus.rvfi_pc_rdata == cfg_trig_pc_i);
    assign permit   = cfg_en_i & ((state_q == CAPTURE) | ((state_q == ARMED) & trig_hit));
    assign cand     = bus.rvfi_valid & permit & filter_hit & ~clear_i;

    assign pop  = fifo_valid & bus.trace_ready_i & ~clear_i;
    // A full FIFO with no pop loses a record. In STREAM mode the new record
    // is lost. In CIRCULAR mode the oldest record is lost.
    assign drop = cand & fifo_full & ~pop;

    // In STOP mode, freeze once this push leaves the FIFO full.
    assign freeze_hit = (mode == STOP) & cand & (((fifo_level == LastSlot) & ~pop) | fifo_full);

    always_comb begin
        state_d = state_q;
        if (!cfg_en_i) begin
            state_d = IDLE;
        end else if (clear_i) begin
            state_d = cfg_trig_en_i ? ARMED : CAPTURE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = cfg_trig_en_i ? ARMED : CAPTURE;
                ARMED:   if (trig_hit) state_d = freeze_hit ? FROZEN : CAPTURE;
                CAPTURE: if (freeze_hit) state_d = FROZEN;
                FROZEN:  state_d = FROZEN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            ts_q       <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ts_q    <= ts_q + 1'b1;
            if (clear_i) begin
                drop_cnt_q <= '0;
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        rec_core          = '0;
        rec_core.trap     = bus.rvfi_trap;
        rec_core.mem_w    = |bus.rvfi_mem_wmask;
        rec_core.mem_r    = |bus.rvfi_mem_rmask;
        rec_core.rd_addr  = bus.rvfi_rd_addr;
        rec_core.rd_wdata = bus.rvfi_rd_wdata;
        rec_core.insn     = bus.rvfi_insn;
        rec_core.pc       = bus.rvfi_pc_rdata;
    end

    assign rec_in = {ts_q, rec_core};

    ibex_trace_fifo #(
        .Depth (Depth),
        .Width (RecW)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (cand),
        .data_i      (rec_in),
        .overwrite_i (mode == CIRCULAR),
        .pop_i       (pop),
        .data_o      (rec_head),
        .valid_o     (fifo_valid),
        .level_o     (fifo_level),
        .full_o      (fifo_full)
    );

    assign bus.trace_valid_o = fifo_valid;
    // Zero the record when it is not valid, so nothing leaks from the
    // unreset array.
    assign bus.trace_rec_o   = fifo_valid ? rec_head : '0;
    assign level_o           = fifo_level;
    assign full_o            = fifo_full;
    assign drop_cnt_o        = drop_cnt_q;
    assign overflow_o        = overflow_q;
    assign capturing_o       = (state_q == CAPTURE);
endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
module tb_ibex_rvfi_trace_buffer;
    localparam int DEPTH = 4;
    localparam int TS_W  = 16;
    localparam int DC_W  = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_en = 1'b0;
    logic [1:0]       cfg_mode = 2'd0;
    logic [2:0]       cfg_filter = 3'd0;
    logic             cfg_trig_en = 1'b0;
    logic [31:0]      cfg_trig_pc = 32'd0;
    logic             clear = 1'b0;
    logic [LVL_W-1:0] level;
    logic             full;
    logic [DC_W-1:0]  drop_cnt;
    logic             overflow;
    logic             capturing;

    int n_checks = 0;
    int n_pass   = 0;

    ibex_rvfi_trace_buffer_if #(.TsWidth(TS_W)) bus ();

    ibex_rvfi_trace_buffer #(
        .Depth        (DEPTH),
        .TsWidth      (TS_W),
        .DropCntWidth (DC_W)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cfg_en_i      (cfg_en),
        .cfg_mode_i    (cfg_mode),
        .cfg_filter_i  (cfg_filter),
        .cfg_trig_en_i (cfg_trig_en),
        .cfg_trig_pc_i (cfg_trig_pc),
        .clear_i       (clear),
        .bus           (bus),
        .level_o       (level),
        .full_o        (full),
        .drop_cnt_o    (drop_cnt),
        .overflow_o    (overflow),
        .capturing_o   (capturing)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else begin
            n_pass++;
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic retire(input logic [31:0] pc, input logic trap, input logic [3:0] rmask);
        bus.rvfi_valid     = 1'b1;
        bus.rvfi_pc_rdata  = pc;
        bus.rvfi_insn      = pc ^ 32'h0000_0013;
        bus.rvfi_rd_wdata  = ~pc;
        bus.rvfi_rd_addr   = pc[6:2];
        bus.rvfi_trap      = trap;
        bus.rvfi_mem_rmask = rmask;
        bus.rvfi_mem_wmask = 4'h0;
        @(posedge clk); #1;
        bus.rvfi_valid     = 1'b0;
        bus.rvfi_trap      = 1'b0;
        bus.rvfi_mem_rmask = 4'h0;
    endtask

    task automatic drain(input string tag, input logic [31:0] exp_pc);
        check({tag, "_valid"}, 128'(bus.trace_valid_o), 128'(1));
        check({tag, "_pc"}, 128'(bus.trace_rec_o[31:0]), 128'(exp_pc));
        bus.trace_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.trace_ready_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    logic [15:0] t0;

    initial begin
        bus.rvfi_valid = 1'b0; bus.rvfi_trap = 1'b0; bus.rvfi_insn = '0;
        bus.rvfi_pc_rdata = '0; bus.rvfi_rd_wdata = '0; bus.rvfi_rd_addr = '0;
        bus.rvfi_mem_rmask = '0; bus.rvfi_mem_wmask = '0; bus.trace_ready_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 128'(bus.trace_valid_o), 128'(0));
        check("rst_level", 128'(level), 128'(0));
        check("rst_drop", 128'(drop_cnt), 128'(0));
        check("rst_capturing", 128'(capturing), 128'(0));
        rst_n = 1'b1;

        // STREAM: 6 retirements into 4 slots, no consumer
        cfg_en = 1'b1; cfg_mode = 2'd0; cfg_filter = 3'b001;
        @(posedge clk); #1;
        check("stream_capturing", 128'(capturing), 128'(1));
        for (int i = 0; i < 6; i++) retire(32'(32'h1000 + 4 * i), 1'b0, 4'h0);
        check("stream_level", 128'(level), 128'(4));
        check("stream_full", 128'(full), 128'(1));
        check("stream_drop", 128'(drop_cnt), 128'(2));
        check("stream_overflow", 128'(overflow), 128'(1));
        check("stream_insn", 128'(bus.trace_rec_o[63:32]), 128'(32'h0000_1013));
        check("stream_wdata", 128'(bus.trace_rec_o[95:64]), 128'(32'hFFFF_EFFF));
        check("stream_rdaddr", 128'(bus.trace_rec_o[100:96]), 128'(5'd0));
        t0 = bus.trace_rec_o[119:104];
        drain("stream_d0", 32'h1000);
        check("stream_ts_step", 128'(bus.trace_rec_o[119:104]), 128'(16'(t0 + 16'd1)));
        drain("stream_d1", 32'h1004);
        drain("stream_d2", 32'h1008);
        drain("stream_d3", 32'h100C);
        check("stream_empty", 128'(bus.trace_valid_o), 128'(0));
        pulse_clear();
        check("clear_drop", 128'(drop_cnt), 128'(0));
        check("clear_overflow", 128'(overflow), 128'(0));

        // STOP: freezes after the 4th record
        cfg_mode = 2'd1;
        pulse_clear();
        for (int i = 0; i < 4; i++) retire(32'(32'h2000 + 4 * i), 1'b0, 4'h0);
        check("stop_frozen", 128'(capturing), 128'(0));
        retire(32'h2010, 1'b0, 4'h0);
        check("stop_level", 128'(level), 128'(4));
        check("stop_drop", 128'(drop_cnt), 128'(0));
        check("stop_overflow", 128'(overflow), 128'(0));
        pulse_clear();
        check("stop_clr_level", 128'(level), 128'(0));
        check("stop_clr_capture", 128'(capturing), 128'(1));

        // CIRCULAR: oldest two entries overwritten
        cfg_mode = 2'd2;
        pulse_clear();
        for (int i = 0; i < 6; i++) retire(32'(32'h100 + 4 * i), 1'b0, 4'h0);
        check("circ_drop", 128'(drop_cnt), 128'(2));
        check("circ_level", 128'(level), 128'(4));
        drain("circ_d0", 32'h108);
        drain("circ_d1", 32'h10C);
        drain("circ_d2", 32'h110);
        drain("circ_d3", 32'h114);

        // Trigger on PC 0x80
        cfg_mode = 2'd0; cfg_trig_en = 1'b1; cfg_trig_pc = 32'h80;
        pulse_clear();
        check("trig_armed", 128'(capturing), 128'(0));
        retire(32'h7C, 1'b0, 4'h0);
        check("trig_pre_level", 128'(level), 128'(0));
        check("trig_pre_capt", 128'(capturing), 128'(0));
        retire(32'h80, 1'b0, 4'h0);
        check("trig_capt", 128'(capturing), 128'(1));
        check("trig_level1", 128'(level), 128'(1));
        retire(32'h84, 1'b0, 4'h0);
        check("trig_level2", 128'(level), 128'(2));
        drain("trig_d0", 32'h80);
        drain("trig_d1", 32'h84);
        cfg_trig_en = 1'b0;

        // Filter traps|mem
        cfg_filter = 3'b110;
        pulse_clear();
        retire(32'h200, 1'b0, 4'h0);
        retire(32'h204, 1'b0, 4'hF);
        retire(32'h208, 1'b1, 4'h0);
        check("filt_level", 128'(level), 128'(2));
        check("filt_memr0", 128'(bus.trace_rec_o[101]), 128'(1));
        check("filt_trap0", 128'(bus.trace_rec_o[103]), 128'(0));
        drain("filt_d0", 32'h204);
        check("filt_trap1", 128'(bus.trace_rec_o[103]), 128'(1));
        check("filt_memr1", 128'(bus.trace_rec_o[101]), 128'(0));
        drain("filt_d1", 32'h208);

        // Full with simultaneous push and pop, then reset mid-drain
        cfg_filter = 3'b001;
        pulse_clear();
        for (int i = 0; i < 4; i++) retire(32'(32'h300 + 4 * i), 1'b0, 4'h0);
        check("pp_full", 128'(full), 128'(1));
        bus.trace_ready_i = 1'b1;
        retire(32'h310, 1'b0, 4'h0);
        check("pp_level", 128'(level), 128'(4));
        check("pp_head", 128'(bus.trace_rec_o[31:0]), 128'(32'h304));
        check("pp_drop", 128'(drop_cnt), 128'(0));
        @(posedge clk); #1;
        check("pp_drain_level", 128'(level), 128'(3));
        rst_n = 1'b0;
        #1;
        check("rstmid_valid", 128'(bus.trace_valid_o), 128'(0));
        check("rstmid_rec", 128'(bus.trace_rec_o), 128'(0));
        check("rstmid_level", 128'(level), 128'(0));
        check("rstmid_full", 128'(full), 128'(0));
        check("rstmid_capturing", 128'(capturing), 128'(0));
        bus.trace_ready_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
